// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// abs_val works on a sign-extended value of up to MAX_W bits; callers truncate the result.
package seq_divider_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int MAX_W     = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    // The magnitude of MIN_INT comes out as unsigned 2^(W-1) after truncation.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] value,
                                                 input logic             is_signed);
        return (is_signed && value[MAX_W-1]) ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, then trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem, dvd_msb};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        // On a borrow the top two bits are both set; with no borrow both are clear.
        q_bit    = ~(diff[WIDTH+1] | diff[WIDTH]);
        next_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider built around a single restoring step.
// Valid/ready on both sides; divide-by-zero and MIN_INT/-1 bypass the iteration.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             divByZero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_r_q, res_r_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [MAX_W-1:0] a_ext, b_ext;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[WIDTH-1]),
        .divisor  (dvs_q),
        .next_rem (step_rem),
        .q_bit    (step_bit)
    );

    always_comb begin
        a_ext = is_signed ? {{(MAX_W-WIDTH){a[WIDTH-1]}}, a} : {{(MAX_W-WIDTH){1'b0}}, a};
        b_ext = is_signed ? {{(MAX_W-WIDTH){b[WIDTH-1]}}, b} : {{(MAX_W-WIDTH){1'b0}}, b};
        a_abs = WIDTH'(abs_val(a_ext, is_signed));
        b_abs = WIDTH'(abs_val(b_ext, is_signed));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        res_r_d   = res_r_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (b == '0) begin
                        quo_d   = '1;
                        res_r_d = a;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else if (is_signed && a == MIN_INT && b == '1) begin
                        quo_d   = MIN_INT;
                        res_r_d = '0;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d     = '0;
                        dvd_d     = a_abs;
                        dvs_d     = b_abs;
                        neg_quo_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = is_signed & a[WIDTH-1];
                        cnt_d     = CNT_W'(WIDTH);
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                // Quotient bits shift into the low end as dividend bits leave the top.
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
                res_r_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            res_r_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            res_r_q   <= res_r_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Q         = quo_q;
    assign R         = res_r_q;
    assign divByZero = dbz_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results, a monitor checks them.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q_o;
    logic [31:0] r_o;
    logic        dbz_o;
    logic        ovf_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    seq_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (q_o),
        .R         (r_o),
        .divByZero (dbz_o),
        .overflow  (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, wanted %h", nm, act, exp);
        end
    endtask

    // Operands are presented at a falling edge; the next rising edge accepts once in_ready is seen.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic s,
                        input bit push, input logic [31:0] eq, input logic [31:0] er,
                        input logic ed, input logic eo, input int lat);
        int   guard;
        exp_t e;
        @(negedge clk);
        a         = av;
        b         = bv;
        is_signed = s;
        in_valid  = 1'b1;
        guard     = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        last_acc = cyc + 1;
        if (push) begin
            e.q = eq; e.r = er; e.dbz = ed; e.ovf = eo; e.lat = lat; e.acc = last_acc;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: samples just after each falling edge, once the driver has settled.
    initial begin
        bit   seen;
        int   first;
        exp_t e;
        seen  = 0;
        first = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid) begin
                if (!seen) begin
                    seen  = 1;
                    first = cyc;
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_result", 32'(out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("Q", q_o, e.q);
                        check("R", r_o, e.r);
                        check("divByZero", 32'(dbz_o), 32'(e.dbz));
                        check("overflow", 32'(ovf_o), 32'(e.ovf));
                        check("latency", 32'(first - e.acc + 1), 32'(e.lat));
                    end
                    seen = 0;
                end
            end else begin
                seen = 0;
            end
        end
    end

    initial begin
        int guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_Q", q_o, 32'd0);
        check("rst_R", r_o, 32'd0);
        check("rst_flags", {30'd0, dbz_o, ovf_o}, 32'd0);
        rst_n = 1'b1;

        send(32'd100, 32'd7, 1'b0, 1, 32'd14, 32'd2, 1'b0, 1'b0, 34);
        send(32'hFFFF_FFF9, 32'd2, 1'b1, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 34);
        send(32'd7, 32'hFFFF_FFFE, 1'b1, 1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 34);
        send(32'd5, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1);
        send(32'd5, 32'd0, 1'b1, 1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1);
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1);
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 34);
        send(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0, 34);
        send(32'h8000_0000, 32'd2, 1'b1, 1, 32'hC000_0000, 32'd0, 1'b0, 1'b0, 34);

        // Backpressure: result must hold while out_ready is low and new operands are ignored.
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        send(32'd1000, 32'd10, 1'b0, 1, 32'd100, 32'd0, 1'b0, 1'b0, 34);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("bp_out_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            a        = 32'd77;
            b        = 32'd3;
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_Q", q_o, 32'd100);
            check("bp_R", r_o, 32'd0);
            check("bp_flags", {30'd0, dbz_o, ovf_o}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_in_ready_after", 32'(in_ready), 32'd1);

        // Reset in the middle of the iteration aborts the operation.
        send(32'h1234_5678, 32'd3, 1'b0, 0, 32'd0, 32'd0, 1'b0, 1'b0, 0);
        repeat (9) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_Q", q_o, 32'd0);
        check("abort_R", r_o, 32'd0);
        check("abort_flags", {30'd0, dbz_o, ovf_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 34);

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
